// File: rtl/cordic_preproc_if.sv
// Angle sample stream into the CORDIC front end: master drives angle_in/angle_valid, slave returns angle_ready.
interface cordic_preproc_if;
  logic [15:0] angle_in;
  logic        angle_valid;
  logic        angle_ready;

  modport master (output angle_in, output angle_valid, input angle_ready);
  modport slave  (input angle_in, input angle_valid, output angle_ready);
endinterface

// File: rtl/cordic_preproc.sv
// CORDIC front end: FIFO-buffered angle fold into [-pi/2, pi/2], seed registered 2 cycles after push; ready = !full, chain never stalls.
// Define CORDIC_PREPROC_SAT_EN to clamp |angle| > pi before folding and raise the sticky sat_flag.
module cordic_preproc #(
  parameter int          FIFO_DEPTH = 8,
  parameter int          PIPE_DEPTH = 16,
  parameter logic [15:0] K_INIT     = 16'h26DD
) (
  input  logic                        clk,
  input  logic                        reset,
  cordic_preproc_if.slave             angle,
  output logic [15:0]                 x_out,
  output logic [15:0]                 y_out,
  output logic [15:0]                 z_out,
  output logic                        valid_out,
  output logic                        tag_out,
  output logic                        tag_valid,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        sat_flag
);
  localparam int                 AW       = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]        FULL_CNT = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0]        CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0]      PTR_ONE  = AW'(1);
  localparam logic signed [15:0] PI       = 16'sh6488;
  localparam logic signed [15:0] HALF_PI  = 16'sh3244;

  logic [15:0]           mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic                  full;
  logic                  push;
  logic                  pop;
  logic signed [15:0]    head;
  logic signed [15:0]    clamped;
  logic signed [15:0]    folded;
  logic                  neg;
  logic                  neg_q;
  logic [PIPE_DEPTH-1:0] tag_v;
  logic [PIPE_DEPTH-1:0] tag_n;

  assign full              = (fifo_count == FULL_CNT);
  assign angle.angle_ready = !full && !reset;
  assign push              = angle.angle_valid && angle.angle_ready;
  assign pop               = (fifo_count != '0);
  assign head              = mem[rd_ptr];

`ifdef CORDIC_PREPROC_SAT_EN
  logic clamp_hit;

  always_comb begin
    clamped   = head;
    clamp_hit = 1'b0;
    if (head > PI) begin
      clamped   = PI;
      clamp_hit = 1'b1;
    end else if (head < -PI) begin
      clamped   = -PI;
      clamp_hit = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      sat_flag <= 1'b0;
    else if (pop && clamp_hit)
      sat_flag <= 1'b1;
  end
`else
  assign clamped  = head;
  assign sat_flag = 1'b0;
`endif

  // +/-pi/2 exactly stays unfolded; only strictly larger magnitudes move by pi.
  always_comb begin
    folded = clamped;
    neg    = 1'b0;
    if (clamped > HALF_PI) begin
      folded = clamped - PI;
      neg    = 1'b1;
    end else if (clamped < -HALF_PI) begin
      folded = clamped + PI;
      neg    = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= angle.angle_in;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)
        rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_ONE;
        2'b01:   fifo_count <= fifo_count - CNT_ONE;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Q3.13 -> Q2.14: the dropped MSB is redundant once |folded| <= pi/2.
  always_ff @(posedge clk) begin
    if (reset) begin
      x_out     <= '0;
      y_out     <= '0;
      z_out     <= '0;
      valid_out <= 1'b0;
      neg_q     <= 1'b0;
      tag_v     <= '0;
      tag_n     <= '0;
    end else begin
      valid_out <= pop;
      if (pop) begin
        x_out <= K_INIT;
        y_out <= '0;
        z_out <= folded << 1;
        neg_q <= neg;
      end
      tag_v <= {tag_v[PIPE_DEPTH-2:0], valid_out};
      tag_n <= {tag_n[PIPE_DEPTH-2:0], valid_out && neg_q};
    end
  end

  assign tag_valid = tag_v[PIPE_DEPTH-1];
  assign tag_out   = tag_n[PIPE_DEPTH-1];
endmodule
